ram_8x72_queue_ctrl: RTL



---
 rtl/ram_8x72_queue_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/ram_8x72_queue_ctrl.sv
// rtl/ram_8x72_queue_ctrl.sv - ready/valid FIFO controller around an external 8x72 two-port RAM
// The queue holds up to DEPTH RAM entries plus one registered output slot.
module ram_8x72_queue_ctrl #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    output logic [3:0]       count,
    output logic [2:0]       R0_addr,
    output logic             R0_en,
    input  logic [WIDTH-1:0] R0_data,
    output logic [2:0]       W0_addr,
    output logic             W0_en,
    output logic [WIDTH-1:0] W0_data
);

    localparam logic [3:0] FULL_CNT = 4'(DEPTH);

    logic [2:0]       wr_ptr;
    logic [2:0]       rd_ptr;
    logic [3:0]       ram_cnt;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;

    logic enq_fire;
    logic deq_fire;
    logic slot_free;
    logic do_read;
    logic bypass;
    logic do_write;

    // enq_ready looks only at registered RAM occupancy, so the producer never
    // sees a combinational path from deq_ready.
    assign enq_ready = (ram_cnt != FULL_CNT);
    assign enq_fire  = enq_valid & enq_ready;
    assign deq_fire  = out_valid & deq_ready;
    assign slot_free = ~out_valid | deq_fire;

    assign do_read   = slot_free & (ram_cnt != 4'd0);
    assign bypass    = slot_free & (ram_cnt == 4'd0) & enq_fire;
    assign do_write  = enq_fire & ~bypass;

    assign R0_en     = do_read;
    assign R0_addr   = rd_ptr;
    assign W0_en     = do_write;
    assign W0_addr   = wr_ptr;
    assign W0_data   = enq_bits;

    assign deq_valid = out_valid;
    assign deq_bits  = out_data;
    assign count     = ram_cnt + {3'b000, out_valid};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= 3'd0;
            rd_ptr    <= 3'd0;
            ram_cnt   <= 4'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            // R0_data is only sampled on a granted read, keeping RAM X out of state.
            if (do_read) begin
                out_data  <= R0_data;
                out_valid <= 1'b1;
                rd_ptr    <= rd_ptr + 3'd1;
            end else if (bypass) begin
                out_data  <= enq_bits;
                out_valid <= 1'b1;
            end else if (slot_free) begin
                out_valid <= 1'b0;
            end

            if (do_write) begin
                wr_ptr <= wr_ptr + 3'd1;
            end

            case ({do_write, do_read})
                2'b10:   ram_cnt <= ram_cnt + 4'd1;
                2'b01:   ram_cnt <= ram_cnt - 4'd1;
                default: ram_cnt <= ram_cnt;
            endcase
        end
    end

endmodule
